// File: rtl/fechadura_param.sv
// fechadura_param - parameterised digit-code lock with retry budget and 7-segment display.
// Optional macro BLOQUEIO_TEMPORIZADO_EN: FALHA auto-clears after BLOQUEIO_CICLOS cycles.
module fechadura_param #(
  parameter int                     DIGITOS         = 6,
  parameter logic [4*DIGITOS-1:0]   CODIGO          = 24'h590281,
  parameter int                     MAX_ERROS       = 1,
  parameter int                     BLOQUEIO_CICLOS = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       insere,
  input  logic [4:1] numero,
  output logic       LED,
  output logic       aberto,
  output logic       bloqueado,
  output logic [2:0] erros,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       F,
  output logic       G
);

  localparam int          IDXW     = $clog2(DIGITOS);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DIGITOS - 1);
  localparam logic [2:0]  ERR_MAX  = 3'(MAX_ERROS);
  localparam logic [6:0]  SEG_A    = 7'b0001000;
  localparam logic [6:0]  SEG_L    = 7'b1110001;

  typedef enum logic [1:0] {ENTRADA, ABERTO, FALHA} state_t;

  state_t          r_state;
  logic [IDXW-1:0] r_idx;
  logic [2:0]      r_erros;
  logic            r_led;
  logic            r_aberto;
  logic            r_bloq;
  logic [6:0]      r_seg;
  logic            r_ins_q;
`ifdef BLOQUEIO_TEMPORIZADO_EN
  logic [15:0]     r_timer;
`endif

  logic            w_strobe;
  logic [3:0]      w_digito;

  assign w_strobe = insere & ~r_ins_q;
  // First digit lives in the most significant nibble.
  assign w_digito = 4'(CODIGO >> (4 * (DIGITOS - 1 - int'(r_idx))));

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = 7'b0000001;
      4'd1:    seg_digit = 7'b1001111;
      4'd2:    seg_digit = 7'b0010010;
      4'd3:    seg_digit = 7'b0000110;
      4'd4:    seg_digit = 7'b1001100;
      4'd5:    seg_digit = 7'b0100100;
      4'd6:    seg_digit = 7'b0100000;
      4'd7:    seg_digit = 7'b0001111;
      4'd8:    seg_digit = 7'b0000000;
      4'd9:    seg_digit = 7'b0000100;
      default: seg_digit = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ENTRADA;
      r_idx    <= '0;
      r_erros  <= '0;
      r_led    <= 1'b0;
      r_aberto <= 1'b0;
      r_bloq   <= 1'b0;
      r_seg    <= 7'b1111111;
      r_ins_q  <= 1'b1;
`ifdef BLOQUEIO_TEMPORIZADO_EN
      r_timer  <= '0;
`endif
    end else begin
      r_ins_q <= insere;
      r_seg   <= seg_digit(numero);
      case (r_state)
        ENTRADA: begin
          if (w_strobe) begin
            if (numero == w_digito) begin
              if (r_idx == IDX_LAST) begin
                r_state  <= ABERTO;
                r_aberto <= 1'b1;
                r_seg    <= SEG_A;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end else if (r_erros < ERR_MAX) begin
              r_erros <= r_erros + 1'b1;
              r_led   <= 1'b1;
            end else begin
              r_state <= FALHA;
              r_bloq  <= 1'b1;
              r_seg   <= SEG_L;
`ifdef BLOQUEIO_TEMPORIZADO_EN
              r_timer <= 16'(BLOQUEIO_CICLOS - 1);
`endif
            end
          end
        end
        ABERTO: r_seg <= SEG_A;
        FALHA: begin
`ifdef BLOQUEIO_TEMPORIZADO_EN
          if (r_timer == 16'd0) begin
            r_state <= ENTRADA;
            r_idx   <= '0;
            r_erros <= '0;
            r_led   <= 1'b0;
            r_bloq  <= 1'b0;
          end else begin
            r_timer <= r_timer - 16'd1;
            r_seg   <= SEG_L;
          end
`else
          r_seg <= SEG_L;
`endif
        end
        default: r_state <= ENTRADA;
      endcase
    end
  end

  assign LED       = r_led;
  assign aberto    = r_aberto;
  assign bloqueado = r_bloq;
  assign erros     = r_erros;
  assign {A, B, C, D, E, F, G} = r_seg;

endmodule

// File: tb/tb_fechadura_param.sv
// tb/tb_fechadura_param.sv - directed self-checking bench for fechadura_param.
module tb_fechadura_param;

`ifdef BLOQUEIO_TEMPORIZADO_EN
  localparam int BC = 4;
`else
  localparam int BC = 1000;
`endif

  logic       clk = 1'b0;
  logic       reset, insere;
  logic [3:0] numero;
  logic       led, aberto, bloq;
  logic [2:0] erros;
  logic       sa, sb, sc, sd, se, sf, sg;

  logic       reset3, insere3;
  logic [3:0] numero3;
  logic       led3, aberto3, bloq3;
  logic [2:0] erros3;
  logic       ta, tb, tc, td, te, tf, tg;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fechadura_param #(.BLOQUEIO_CICLOS(BC)) dut (
    .clk(clk), .reset(reset), .insere(insere), .numero(numero),
    .LED(led), .aberto(aberto), .bloqueado(bloq), .erros(erros),
    .A(sa), .B(sb), .C(sc), .D(sd), .E(se), .F(sf), .G(sg)
  );

  fechadura_param #(.DIGITOS(3), .CODIGO(12'h123), .MAX_ERROS(0), .BLOQUEIO_CICLOS(BC)) dut3 (
    .clk(clk), .reset(reset3), .insere(insere3), .numero(numero3),
    .LED(led3), .aberto(aberto3), .bloqueado(bloq3), .erros(erros3),
    .A(ta), .B(tb), .C(tc), .D(td), .E(te), .F(tf), .G(tg)
  );

  wire [6:0] seg  = {sa, sb, sc, sd, se, sf, sg};
  wire [6:0] seg3 = {ta, tb, tc, td, te, tf, tg};

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1; insere = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic strobe(input logic [3:0] d);
    @(negedge clk);
    numero = d; insere = 1'b1;
    @(negedge clk);
    insere = 1'b0;
    @(negedge clk);
  endtask

  task automatic strobe3(input logic [3:0] d);
    @(negedge clk);
    numero3 = d; insere3 = 1'b1;
    @(negedge clk);
    insere3 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [6:0] exp_seg [16];
    exp_seg = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
                7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
    @(negedge clk);
    reset = 1'b1; insere = 1'b1; numero = 4'd5;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({aberto, bloq, led, erros, seg} !== {1'b0, 1'b0, 1'b0, 3'd0, 7'b1111111}) begin
      failures++;
      $display("FAIL reset_outputs got ab=%b bl=%b led=%b erros=%0d seg=%b want 0 0 0 0 1111111",
               aberto, bloq, led, erros, seg);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (dut.r_idx !== 3'd0) begin
      failures++;
      $display("FAIL reset_insere_high got idx=%0d want 0", dut.r_idx);
    end
    insere = 1'b0;
    for (int i = 0; i < 16; i++) begin
      numero = 4'(i);
      @(negedge clk);
      checks++;
      if (seg !== exp_seg[i]) begin
        failures++;
        $display("FAIL seg_decode_%0d got %b want %b", i, seg, exp_seg[i]);
      end
    end
  endtask

  task automatic test_open;
    logic [3:0] seq [6];
    seq = '{4'd5, 4'd9, 4'd0, 4'd2, 4'd8, 4'd1};
    do_reset();
    for (int i = 0; i < 5; i++) strobe(seq[i]);
    checks++;
    if (aberto !== 1'b0 || dut.r_idx !== 3'd5) begin
      failures++;
      $display("FAIL open_before_last got ab=%b idx=%0d want 0 5", aberto, dut.r_idx);
    end
    strobe(seq[5]);
    checks++;
    if ({aberto, led, erros, seg} !== {1'b1, 1'b0, 3'd0, 7'b0001000}) begin
      failures++;
      $display("FAIL open_final got ab=%b led=%b erros=%0d seg=%b want 1 0 0 0001000",
               aberto, led, erros, seg);
    end
    strobe(4'd3);
    checks++;
    if ({aberto, bloq, erros, seg} !== {1'b1, 1'b0, 3'd0, 7'b0001000}) begin
      failures++;
      $display("FAIL open_sticky got ab=%b bl=%b erros=%0d seg=%b want 1 0 0 0001000",
               aberto, bloq, erros, seg);
    end
  endtask

  task automatic test_retry;
    logic [3:0] seq [5];
    seq = '{4'd9, 4'd0, 4'd2, 4'd8, 4'd1};
    do_reset();
    strobe(4'd5);
    strobe(4'd3);
    checks++;
    if ({led, erros, dut.r_idx} !== {1'b1, 3'd1, 3'd1}) begin
      failures++;
      $display("FAIL retry_after_wrong got led=%b erros=%0d idx=%0d want 1 1 1", led, erros, dut.r_idx);
    end
    for (int i = 0; i < 5; i++) strobe(seq[i]);
    checks++;
    if ({aberto, led, erros} !== {1'b1, 1'b1, 3'd1}) begin
      failures++;
      $display("FAIL retry_final got ab=%b led=%b erros=%0d want 1 1 1", aberto, led, erros);
    end
  endtask

  task automatic test_fail;
    do_reset();
    strobe(4'd5);
    strobe(4'd3);
    strobe(4'd4);
    checks++;
    if ({bloq, aberto, led, erros, seg} !== {1'b1, 1'b0, 1'b1, 3'd1, 7'b1110001}) begin
      failures++;
      $display("FAIL fail_enter got bl=%b ab=%b led=%b erros=%0d seg=%b want 1 0 1 1 1110001",
               bloq, aberto, led, erros, seg);
    end
`ifndef BLOQUEIO_TEMPORIZADO_EN
    strobe(4'd9);
    strobe(4'd0);
    checks++;
    if ({bloq, aberto, erros, dut.r_idx, seg} !== {1'b1, 1'b0, 3'd1, 3'd1, 7'b1110001}) begin
      failures++;
      $display("FAIL fail_ignore got bl=%b ab=%b erros=%0d idx=%0d seg=%b want 1 0 1 1 1110001",
               bloq, aberto, erros, dut.r_idx, seg);
    end
`endif
  endtask

  task automatic test_hold_and_reset_race;
    do_reset();
    @(negedge clk);
    numero = 4'd5; insere = 1'b1;
    repeat (10) @(negedge clk);
    numero = 4'd9;
    repeat (3) @(negedge clk);
    insere = 1'b0;
    @(negedge clk);
    checks++;
    if ({dut.r_idx, erros} !== {3'd1, 3'd0}) begin
      failures++;
      $display("FAIL hold_one_strobe got idx=%0d erros=%0d want 1 0", dut.r_idx, erros);
    end
    strobe(4'd3);
    @(negedge clk);
    reset = 1'b1; numero = 4'd9; insere = 1'b1;
    @(negedge clk);
    reset = 1'b0; insere = 1'b0;
    checks++;
    if ({dut.r_idx, erros, led} !== {3'd0, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_beats_strobe got idx=%0d erros=%0d led=%b want 0 0 0", dut.r_idx, erros, led);
    end
    @(negedge clk);
  endtask

  task automatic test_lockout;
    int cnt;
    do_reset();
    strobe(4'd5);
    strobe(4'd3);
    @(negedge clk);
    numero = 4'd4; insere = 1'b1;
    @(posedge clk);
    #1;
    cnt = 0;
    while (bloq === 1'b1 && cnt < 150) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    insere = 1'b0;
`ifdef BLOQUEIO_TEMPORIZADO_EN
    checks++;
    if (cnt !== 4) begin
      failures++;
      $display("FAIL lockout_cycles got %0d want 4", cnt);
    end
    checks++;
    if ({dut.r_idx, erros, led, aberto} !== {3'd0, 3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL lockout_return got idx=%0d erros=%0d led=%b want 0 0 0", dut.r_idx, erros, led);
    end
`else
    checks++;
    if (cnt < 100) begin
      failures++;
      $display("FAIL lockout_sticky got %0d cycles want >=100", cnt);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_param3;
    @(negedge clk);
    reset3 = 1'b1; insere3 = 1'b0; numero3 = 4'd0;
    @(negedge clk);
    reset3 = 1'b0;
    @(negedge clk);
    strobe3(4'd1);
    strobe3(4'd2);
    strobe3(4'd3);
    checks++;
    if ({aberto3, bloq3, led3, seg3} !== {1'b1, 1'b0, 1'b0, 7'b0001000}) begin
      failures++;
      $display("FAIL p3_open got ab=%b bl=%b led=%b seg=%b want 1 0 0 0001000", aberto3, bloq3, led3, seg3);
    end
    @(negedge clk);
    reset3 = 1'b1;
    @(negedge clk);
    reset3 = 1'b0;
    @(negedge clk);
    strobe3(4'd1);
    @(negedge clk);
    numero3 = 4'd5; insere3 = 1'b1;
    @(negedge clk);
    insere3 = 1'b0;
    checks++;
    if ({bloq3, aberto3, led3, erros3} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL p3_fail got bl=%b ab=%b led=%b erros=%0d want 1 0 0 0", bloq3, aberto3, led3, erros3);
    end
  endtask

  initial begin
    reset = 1'b1; insere = 1'b0; numero = 4'd0;
    reset3 = 1'b1; insere3 = 1'b0; numero3 = 4'd0;
    test_reset();
    test_open();
    test_retry();
    test_fail();
    test_hold_and_reset_race();
    test_lockout();
    test_param3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
